// File: rtl/branch_resolve.sv
// Decode-stage branch resolution: holds decode while operands are pending, compares
// them for BEQ/BNE, and issues a registered one-cycle PC redirect plus flush.
module branch_resolve #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic             br_ne,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_a_ready,
  input  logic             op_b_ready,
  input  logic [PC_W-1:0]  br_target,
  output logic             stall,
  output logic             pc_src,
  output logic [PC_W-1:0]  pc_target,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nx;
  logic             hold_ne;
  logic [PC_W-1:0]  hold_target;
  logic             both_ready;
  logic             resolve;
  logic             latch;
  logic             taken;
  logic             use_ne;
  logic [PC_W-1:0]  use_target;

  // Handshake: a branch is offered while br_valid=1 and consumed on the edge where
  // both operands are ready; stall=1 means decode must hold everything as-is.
  assign both_ready = op_a_ready && op_b_ready;

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    resolve    = 1'b0;
    latch      = 1'b0;
    use_ne     = br_ne;
    use_target = br_target;
    case (state)
      IDLE: begin
        if (br_valid) begin
          if (both_ready) begin
            resolve = 1'b1;
          end else begin
            stall    = 1'b1;
            latch    = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        // Decode is frozen, so the type/target come from the holding registers.
        use_ne     = hold_ne;
        use_target = hold_target;
        stall      = !both_ready;
        resolve    = both_ready;
      end
      REDIR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    taken = resolve && ((op_a == op_b) ^ use_ne);
    if (resolve) begin
      state_nx = taken ? REDIR : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_src      <= 1'b0;
      flush       <= 1'b0;
      pc_target   <= '0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
      hold_ne     <= 1'b0;
      hold_target <= '0;
    end else begin
      state  <= state_nx;
      pc_src <= taken;
      flush  <= taken;
      if (taken) begin
        pc_target <= use_target;
      end
      if (latch) begin
        hold_ne     <= br_ne;
        hold_target <= br_target;
      end
      if (resolve && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + CNT_ONE;
      end
      if (taken && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-written reset/saturation
// sequences, and randomized traffic checked against a transaction-level model.
module tb_branch_resolve;

  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk;
  logic             reset;
  logic             br_valid;
  logic             br_ne;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_a_ready;
  logic             op_b_ready;
  logic [PC_W-1:0]  br_target;
  logic             stall;
  logic             pc_src;
  logic [PC_W-1:0]  pc_target;
  logic             flush;
  logic [CW-1:0]    branch_cnt;
  logic [CW-1:0]    taken_cnt;

  int total;
  int bad;

  // model: pending branch, redirect in progress, counters as plain integers
  bit          m_pend;
  bit          m_pend_ne;
  logic [31:0] m_pend_tgt;
  bit          m_redir;
  logic [31:0] m_tgt;
  int          m_bc;
  int          m_tc;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          v;
    bit          ne;
    logic [31:0] a;
    logic [31:0] b;
    bit          ar;
    bit          br;
    logic [31:0] tgt;
    bit          e_stall;
    bit          e_src;
    logic [31:0] e_tgt;
    int          e_bc;
    int          e_tc;
  } vec_t;

  vec_t vecs[18];

  branch_resolve #(.WIDTH(WIDTH), .PC_W(PC_W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .br_valid   (br_valid),
    .br_ne      (br_ne),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_a_ready (op_a_ready),
    .op_b_ready (op_b_ready),
    .br_target  (br_target),
    .stall      (stall),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .flush      (flush),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit ne, input logic [31:0] a,
                       input logic [31:0] b, input bit ar, input bit br, input logic [31:0] tgt);
    reset      = rst;
    br_valid   = v;
    br_ne      = ne;
    op_a       = a;
    op_b       = b;
    op_a_ready = ar;
    op_b_ready = br;
    br_target  = tgt;
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  // Advance the model over one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit          rdy;
    bit          ne;
    logic [31:0] tg;
    rdy = op_a_ready && op_b_ready;
    if (reset) begin
      m_pend  = 0;
      m_redir = 0;
      m_tgt   = 0;
      m_bc    = 0;
      m_tc    = 0;
    end else if (m_redir) begin
      m_redir = 0;
    end else if (m_pend || br_valid) begin
      ne = m_pend ? m_pend_ne : br_ne;
      tg = m_pend ? m_pend_tgt : br_target;
      if (rdy) begin
        m_pend = 0;
        m_bc   = sat_inc(m_bc);
        if ((op_a == op_b) != ne) begin
          m_tc    = sat_inc(m_tc);
          m_redir = 1;
          m_tgt   = tg;
        end
      end else if (!m_pend) begin
        m_pend     = 1;
        m_pend_ne  = br_ne;
        m_pend_tgt = br_target;
      end
    end
  endtask

  task automatic check_model();
    bit exp_stall;
    exp_stall = !m_redir && (m_pend || br_valid) && !(op_a_ready && op_b_ready);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("pc_src", 32'(pc_src), 32'(m_redir));
    chk("flush", 32'(flush), 32'(m_redir));
    if (m_redir) chk("pc_target", pc_target, m_tgt);
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
    chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
  endtask

  // Inputs already applied: settle, compare, then take the edge.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_pend = 0; m_pend_ne = 0; m_pend_tgt = 0; m_redir = 0; m_tgt = 0; m_bc = 0; m_tc = 0;
    drive(1, 0, 0, 0, 0, 1, 1, 0);

    // chk rst v ne a b ar br tgt | stall src tgt bc tc
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       0, 0};
    vecs[2]  = '{1, 0, 1, 0, 'h1234, 'h1234, 1, 1, 'h400, 0, 0, 0,   0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 1, 'h400,   1, 1};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       1, 1};
    vecs[5]  = '{1, 0, 1, 1, 5, 5, 1, 1, 0,           0, 0, 0,       1, 1};
    vecs[6]  = '{1, 0, 1, 0, 7, 8, 1, 1, 0,           0, 0, 0,       2, 1};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       3, 1};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       3, 1};
    vecs[9]  = '{1, 0, 1, 0, 9, 9, 1, 0, 'h80,        1, 0, 0,       3, 1};
    vecs[10] = '{1, 0, 1, 0, 9, 9, 1, 0, 0,           1, 0, 0,       3, 1};
    vecs[11] = '{1, 0, 1, 0, 9, 9, 1, 0, 0,           1, 0, 0,       3, 1};
    vecs[12] = '{1, 0, 1, 0, 9, 9, 1, 1, 0,           0, 0, 0,       3, 1};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 1, 'h80,    4, 2};
    vecs[14] = '{1, 0, 1, 0, 1, 1, 1, 1, 'h10,        0, 0, 0,       4, 2};
    vecs[15] = '{1, 0, 1, 0, 1, 1, 1, 1, 'h10,        0, 1, 'h10,    5, 3};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       5, 3};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 1, 1, 0,           0, 0, 0,       5, 3};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].ne, vecs[i].a, vecs[i].b,
            vecs[i].ar, vecs[i].br, vecs[i].tgt);
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
        chk($sformatf("vec%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].e_src));
        chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_src));
        if (vecs[i].e_src) chk($sformatf("vec%0d_target", i), pc_target, vecs[i].e_tgt);
        chk($sformatf("vec%0d_bcnt", i), 32'(branch_cnt), 32'(vecs[i].e_bc));
        chk($sformatf("vec%0d_tcnt", i), 32'(taken_cnt), 32'(vecs[i].e_tc));
      end
      @(posedge clk);
      model_edge();
      #1;
    end

    // reset while waiting on an operand
    drive(0, 1, 0, 3, 3, 1, 0, 'h44); step();
    drive(1, 0, 0, 3, 3, 1, 0, 0);    step();
    drive(0, 0, 0, 3, 3, 1, 1, 0);    step();
    step();
    chk("rst_wait_bcnt", 32'(branch_cnt), 0);
    // reset on the resolving cycle of a taken branch
    drive(0, 1, 0, 6, 6, 1, 0, 'h50); step();
    drive(1, 0, 0, 6, 6, 1, 1, 'h50); step();
    drive(0, 0, 0, 0, 0, 1, 1, 0);    step();
    chk("rst_redir_src", 32'(pc_src), 0);
    step();

    // randomized traffic, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3);
      drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1), a,
            $urandom_range(0, 1) ? a : 32'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), $urandom);
      step();
    end

    // saturation: taken BEQs until both counters are pinned at all-ones
    drive(1, 0, 0, 0, 0, 1, 1, 0); step();
    for (int i = 0; i < CMAX + 2; i++) begin
      drive(0, 1, 0, i, i, 1, 1, 32'(i)); step();
      drive(0, 1, 0, i, i, 1, 1, 0);      step();
    end
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    chk("sat_bcnt", 32'(branch_cnt), CMAX);
    chk("sat_tcnt", 32'(taken_cnt), CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Decode-stage branch resolution unit for the pipelined CPU.
- Accepts a BEQ/BNE branch and its two register operands, and stalls decode while either operand is still pending.
- Compares the operands for equality and, on a taken branch, drives a registered PC redirect plus a one-cycle fetch/decode flush.
- Keeps saturating branch and taken-branch counters for performance readout.

Parameters:
WIDTH, 32, operand data width in bits
PC_W, 32, program counter / target address width in bits
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
br_valid  input  1  decode holds a conditional branch this cycle
br_ne  input  1  branch type: 0 = BEQ (taken if equal), 1 = BNE (taken if not equal)
op_a  input  WIDTH  first register operand (post-forwarding)
op_b  input  WIDTH  second register operand (post-forwarding)
op_a_ready  input  1  op_a is valid; 0 while a load result is still pending
op_b_ready  input  1  op_b is valid; 0 while a load result is still pending
br_target  input  PC_W  computed branch target address
stall  output  1  freeze PC and IF/ID register (combinational)
pc_src  output  1  select pc_target as next PC (registered)
pc_target  output  PC_W  redirect address, valid while pc_src=1 (registered)
flush  output  1  clear IF/ID register (registered; asserts with pc_src)
branch_cnt  output  CNT_W  branches resolved since reset
taken_cnt  output  CNT_W  taken branches since reset

Behaviour:
- Reset: state=IDLE; pc_src=0, flush=0, pc_target=0, branch_cnt=0, taken_cnt=0; stall=0 combinationally. Reset overrides everything, including a pending redirect in the same cycle.
- Taken condition: taken = (op_a == op_b) XOR br_ne, evaluated over the full WIDTH on the operand values in the resolving cycle.
- FSM states: IDLE, WAIT, REDIR.
- IDLE, br_valid=1, both operands ready:
  - Resolve in this cycle; stall=0.
  - If taken: register pc_target<=br_target and go to REDIR.
  - If not taken: stay in IDLE.
  - branch_cnt increments.
- IDLE, br_valid=1, either operand not ready:
  - stall=1 in the same cycle.
  - Latch br_ne and br_target into internal holding registers; go to WAIT.
- IDLE, br_valid=0: no action; all outputs idle.
- WAIT:
  - stall = !(op_a_ready && op_b_ready).
  - When both are ready, resolve using the live op_a/op_b and the latched type/target, with the same transitions as IDLE. stall drops to 0 in that cycle.
  - br_valid is ignored in WAIT; decode is frozen.
  - No timeout; WAIT may last any number of cycles.
- REDIR:
  - pc_src=1, flush=1 for exactly one cycle; pc_target holds the registered target.
  - Next state is IDLE unconditionally.
  - br_valid is ignored; the instruction in decode is being flushed, so no new branch is accepted and neither counter changes.
  - stall=0.
- Latency: branch resolved in cycle N produces pc_src/flush in cycle N+1 only. Back-to-back taken branches are impossible; a branch after a not-taken branch may be accepted in the very next cycle.
- Counters:
  - branch_cnt increments once per resolution; taken_cnt increments additionally when the branch is taken. Both update on the resolving edge.
  - Both saturate at all-ones (2^CNT_W-1) and never wrap.
- pc_target retains its last value outside REDIR; consumers qualify it with pc_src.
- Reset asserted mid-WAIT or mid-REDIR: pending branch dropped, no redirect emitted, return to IDLE next edge.

Test Plan:
- Reset, then BEQ with op_a=op_b=0x1234, both ready, br_target=0x400 -> cycle N stall=0; cycle N+1 pc_src=1, flush=1, pc_target=0x400 for one cycle; branch_cnt=1, taken_cnt=1.
- BNE with op_a=op_b=5, both ready -> no pc_src/flush in the next 3 cycles; branch_cnt=1, taken_cnt=0; second BEQ in cycle N+1 (op_a=7, op_b=8) accepted, not taken, branch_cnt=2.
- BEQ, br_target=0x80, op_b_ready=0 for 3 cycles, then ready with op_a=op_b=9 (br_target input changed to 0x0 meanwhile) -> stall=1 for exactly 3 cycles; redirect next cycle with pc_target=0x80 (latched value).
- Taken branch, br_valid held high during REDIR -> one flush pulse only, counters increment once, state IDLE after.
- Reset asserted in WAIT and, separately, on the cycle before REDIR -> pc_src and flush never assert; counters 0; stall=0 after reset.
- Force counters near saturation (2^CNT_W-2) and issue 3 taken BEQs -> both counters stop at 0xFFFF.
